divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset; synchronous and active-high.
REQ-004 Port: ctrl_DIV  input  1  start pulse; samples operands when high.
REQ-005 Port: data_operandA  input  32  dividend, two's complement.
REQ-006 Port: data_operandB  input  32  divisor, two's complement.
REQ-007 Port: data_result  output  32  quotient, two's complement, truncated toward zero.
REQ-008 Port: data_exception  output  1  divide-by-zero or overflow flag for the current result.
REQ-009 Port: data_resultRDY  output  1  one-cycle pulse marking a valid data_result/data_exception.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-011 A cycle with ctrl_DIV=1 SHALL capture |A| and |B| and the sign bits, clear the 5-bit iteration counter and the 33-bit partial remainder, and enter RUN; this applies in any state.
REQ-012 Operands SHALL be sampled only in the ctrl_DIV cycle; later changes have no effect.
REQ-013 RUN SHALL perform one restoring step per cycle for 32 cycles:
- shift {remainder, quotient} left by 1;
- trial-subtract |B| from the 33-bit remainder;
- if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore the remainder and set the LSB to 0.
REQ-014 When the counter reaches 31, RUN SHALL go to DONE; DONE SHALL return to IDLE on the next cycle unless ctrl_DIV=1.
REQ-015 data_resultRDY SHALL be 1 only while in DONE, in cycle N+33 for ctrl_DIV in cycle N; it SHALL be 0 in all other cycles.
REQ-016 The final quotient SHALL be negated when A[31] xor B[31] is set and the unsigned quotient is non-zero.
REQ-017 If the divisor is zero, data_exception SHALL be 1 and data_result SHALL be 0; latency is unchanged.
REQ-018 If A=0x80000000 and B=0xFFFFFFFF, data_exception SHALL be 1 and data_result SHALL be 0.
REQ-019 In all other cases data_exception SHALL be 0.
REQ-020 data_result and data_exception SHALL be registered at the DONE transition and held until the next ctrl_DIV or reset; they are valid for sampling only when data_resultRDY=1.
REQ-021 ctrl_DIV in RUN SHALL abort the current operation with no resultRDY pulse and restart with the new operands.
REQ-022 ctrl_DIV in DONE SHALL still pulse data_resultRDY for the finishing result in that cycle and start the new operation.
REQ-023 Dividend 0x80000000 SHALL use magnitude 2^31 via the 33-bit datapath with no wrap.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, counter=0, remainder=0, data_result=0, data_exception=0 and data_resultRDY=0.
REQ-025 reset SHALL take priority over a simultaneous ctrl_DIV.
REQ-026 A reset during RUN SHALL discard the operation with no resultRDY pulse.

Structure
REQ-027 A shared constants file SHALL hold DIV_WIDTH=32, DIV_ITERS=32 and the IDLE/RUN/DONE state encoding; the multiplier and divider SHALL share it.
REQ-028 A single sub-module div_step SHALL implement one combinational shift/trial-subtract step.
- Inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor.
- Outputs: the next remainder and next quotient.
REQ-029 State, counter and datapath registers SHALL be in the top module; there are no memories or multicycle paths.

Verification
REQ-030 A=100, B=7, ctrl_DIV in cycle 0 -> in cycle 33 only: resultRDY=1, result=14, exception=0.
REQ-031 A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14); A=-7, B=-100 -> result=0, exception=0.
REQ-032 A=5, B=0 -> resultRDY in cycle 33, exception=1, result=0; A=0x80000000, B=0xFFFFFFFF -> exception=1, result=0.
REQ-033 A=0x80000000, B=2 -> result=0xC0000000, exception=0.
REQ-034 Start 100/7, then ctrl_DIV with 81/9 in cycle 10 -> no pulse in cycle 33, pulse in cycle 43 with result=9.
REQ-035 Start 100/7, reset in cycle 20 -> all outputs 0 and no pulse through cycle 40; a following 6/3 gives 2 after 33 cycles.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants for the iterative arithmetic units (multiplier, divider).
// Holds the datapath width, the iteration count, the common three-state FSM
// encoding and a two's-complement magnitude helper.
package divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement value. 0x80000000 maps to
    // 0x80000000 (2^31), which is exact when read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   33-bit partial remainder
//   quo_in   32-bit quotient/dividend shift register
//   divisor  32-bit unsigned divisor magnitude
//   rem_out  next partial remainder
//   quo_out  next quotient (new bit in LSB)
module div_step
    import divider_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_in,
    input  logic [DIV_WIDTH-1:0] quo_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH:0]   rem_out,
    output logic [DIV_WIDTH-1:0] quo_out
);

    logic [DIV_WIDTH+1:0] rem_sh;
    logic                 fits;

    always_comb begin
        // Shift {remainder, quotient} left by one; an extra top bit keeps the
        // trial comparison exact even when the remainder is already wide.
        rem_sh  = {rem_in, quo_in[DIV_WIDTH-1]};
        fits    = (rem_sh >= {2'b00, divisor});
        rem_out = fits ? (DIV_WIDTH+1)'(rem_sh - {2'b00, divisor})
                       : rem_sh[DIV_WIDTH:0];
        quo_out = {quo_in[DIV_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divider.sv
// Signed 32-bit iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   ctrl_DIV        start pulse; operands sampled in this cycle only
//   data_operandA   dividend (two's complement)
//   data_operandB   divisor  (two's complement)
//   data_result     quotient truncated toward zero; 0 on exception
//   data_exception  divide-by-zero or 0x80000000 / -1 overflow
//   data_resultRDY  one-cycle pulse while the result is valid
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    state_t state, state_nxt;

    logic [4:0]           count;
    logic [DIV_WIDTH:0]   rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 neg_q;
    logic                 div_zero;
    logic                 ovf;

    logic [DIV_WIDTH:0]   rem_nxt;
    logic [DIV_WIDTH-1:0] quo_nxt;
    logic [DIV_WIDTH-1:0] q_signed;
    logic                 last_iter;

    div_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign last_iter = (state == RUN) && (count == LAST_ITER);

    // Negate only a non-zero magnitude so a zero quotient never becomes -0.
    always_comb begin
        q_signed = quo_nxt;
        if (neg_q && (quo_nxt != '0)) begin
            q_signed = ~quo_nxt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        data_resultRDY = 1'b0;
        case (state)
            IDLE: state_nxt = IDLE;
            RUN:  if (count == LAST_ITER) state_nxt = DONE;
            DONE: begin
                data_resultRDY = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A start request restarts from any state, including an abort of RUN.
        if (ctrl_DIV) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_DIV) begin
            count    <= '0;
            rem      <= '0;
            quo      <= abs_val(data_operandA);
            divisor  <= abs_val(data_operandB);
            neg_q    <= data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
            div_zero <= (data_operandB == '0);
            ovf      <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (state == RUN) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + 5'd1;
            // Result is taken straight from the final step so it is ready
            // in the same edge that enters DONE.
            if (last_iter) begin
                data_exception <= div_zero | ovf;
                data_result    <= (div_zero | ovf) ? '0 : q_signed;
            end
        end
    end

endmodule
